mnist_nn_key_pio: RTL and testbench
===================================

// Module: mnist_nn_key_pio
// PURPOSE
//  Avalon-MM slave input PIO: samples WIDTH asynchronous push-button/switch pins,
//  synchronises and debounces them, and latches edges into a sticky capture register.
//  Raises a level IRQ to the Nios II for enabled captured edges.
//  Input counterpart of the output PIO that drives out_port; same s1 bus timing.
// PARAMETERS
//  WIDTH            4         number of input pins (1..32)
//  DEBOUNCE_CYCLES  500000    consecutive clk cycles a change must persist (>=1)
//  EDGE_TYPE        1         0=rising, 1=falling, 2=any edge captured
//  RESET_LEVEL      {WIDTH{1'b1}}  reset value of sync and debounced state (keys active-low)
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      s1 word address
//  chipselect  in   1      s1 select
//  write_n     in   1      s1 write strobe, active-low
//  writedata   in   32     s1 write data
//  readdata    out  32     s1 read data, combinational, zero wait states
//  in_port     in   WIDTH  raw asynchronous pins
//  irq         out  1      level interrupt, active-high
// BEHAVIOUR
//  Reset: sync flops and deb <= RESET_LEVEL; counters, irq_mask, edge_cap <= 0; irq=0.
//  Register map (readdata upper bits [31:WIDTH] always 0):
//   0 DATA     R   debounced pin state deb; writes ignored
//   1 -        R   reads 0; writes ignored
//   2 IRQMASK  RW  irq_mask[WIDTH-1:0]; write when chipselect & ~write_n & addr==2
//   3 EDGECAP  R/W1C  edge_cap; write clears bits where writedata[i]==1
//  Read: readdata = mux(address) of current registers, same cycle; no read side effects.
//  Sync: 2-flop synchroniser per bit -> s[i].
//  Debounce per bit: cnt increments while s[i] != deb[i], clears when equal;
//   when cnt reaches DEBOUNCE_CYCLES-1 and still differing, deb[i] <= s[i], cnt <= 0.
//   Pin-to-deb latency: 2 + DEBOUNCE_CYCLES clk. Glitch shorter than DEBOUNCE_CYCLES: no change.
//   Counter width $clog2(DEBOUNCE_CYCLES+1); saturates never (cleared on update).
//  Edge detect on deb (deb_q = deb delayed 1 clk): rise = deb & ~deb_q, fall = ~deb & deb_q;
//   set vector per EDGE_TYPE. edge_cap[i] <= set[i] | (edge_cap[i] & ~clr[i]).
//   Simultaneous set and W1C on same bit: set wins (bit stays 1).
//  irq = |(edge_cap & irq_mask), registered: asserts 1 clk after edge_cap/mask update.
//  Mask write does not clear edge_cap; unmasking a pending bit raises irq next clk.
//  Reset mid-debounce: count discarded, deb returns to RESET_LEVEL, no edge generated
//   on reset release (deb_q also reset to RESET_LEVEL).
//  Writes to address 0/1 and to bits >= WIDTH have no effect.
// STRUCTURE
//  Package mnist_nn_pio_pkg: register offsets PIO_DATA=0, PIO_IRQMASK=2,
//   PIO_EDGECAP=3; EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
//  Sub-module mnist_nn_debounce (1 bit: sync chain + counter + deb flop),
//   instantiated WIDTH times via generate; top holds edge, mask, irq, bus mux.
// TESTING (bench: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, RESET_LEVEL=4'hF)
//  Reset, in_port=4'hF held -> read addr0 = 32'h0000000F, addr3 = 0, irq=0 throughout.
//  in_port[0] 1->0 held -> deb[0]=0 exactly 6 clk later; edge_cap=4'h1; irq stays 0 (mask 0).
//  3-clk low glitch on in_port[1] -> addr0 stays 4'hF-ish for bit1, edge_cap[1]=0.
//  Write addr2=4'h1 with edge_cap[0]=1 -> irq=1 next clk; write addr3=4'h1 -> edge_cap=0, irq=0 next clk.
//  Falling edge on bit2 lands same clk as W1C write 4'h4 -> edge_cap[2] remains 1.
//  Assert reset_n low mid-debounce of bit3 -> after release deb=4'hF, edge_cap=0, irq=0.

Source files
------------

// File: rtl/mnist_nn_pio_pkg.sv
// ---------------------------------------------------------------------------
// mnist_nn_pio_pkg
// Shared definitions for the key/switch input PIO:
//   - s1 register word offsets
//   - edge-capture mode encodings
// ---------------------------------------------------------------------------
package mnist_nn_pio_pkg;

  localparam int PIO_DATA_W = 32;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_RSVD    = 2'd1;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage : mnist_nn_pio_pkg

// File: rtl/mnist_nn_debounce.sv
// ---------------------------------------------------------------------------
// mnist_nn_debounce
// One-bit input conditioner: 2-flop synchroniser followed by a persistence
// counter. The debounced output follows the synchronised pin only after the
// pin has differed from it for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_pin      raw asynchronous pin
//   o_deb      debounced, clock-domain-safe pin state
// ---------------------------------------------------------------------------
module mnist_nn_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_pin,
  output logic o_deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= RESET_BIT;
      r_sync2 <= RESET_BIT;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  // Persistence counter: runs while the pin disagrees with the debounced
  // state; the last cycle of the window commits the new level and rearms.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= {CNT_W{1'b0}};
      r_deb <= RESET_BIT;
    end else if (r_sync2 != r_deb) begin
      if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= {CNT_W{1'b0}};
    end
  end

  assign o_deb = r_deb;

endmodule : mnist_nn_debounce

// File: rtl/mnist_nn_key_pio.sv
// ---------------------------------------------------------------------------
// mnist_nn_key_pio
// Avalon-MM s1 slave input PIO for push-buttons/switches. Each pin is
// synchronised and debounced; selected edges of the debounced state are
// latched into a sticky W1C capture register, and a registered level IRQ is
// raised for any captured edge whose mask bit is set.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        s1 word address (0 DATA, 2 IRQMASK, 3 EDGECAP)
//   chipselect     s1 select
//   write_n        s1 write strobe, active-low
//   writedata      s1 write data
//   readdata       s1 read data, combinational (zero wait states)
//   in_port        raw asynchronous pins
//   irq            level interrupt, active-high
// ---------------------------------------------------------------------------
module mnist_nn_key_pio
  import mnist_nn_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [PIO_DATA_W-1:0] writedata,
  output logic [PIO_DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_en;

  logic [WIDTH-1:0] r_deb_q;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic             r_irq;

  // Per-pin synchroniser + debouncer.
  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    mnist_nn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_LEVEL[g])
    ) u_deb (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_pin     (in_port[g]),
      .o_deb     (w_deb[g])
    );
  end

  // Bits of writedata above WIDTH have no register behind them.
  if (WIDTH < PIO_DATA_W) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[PIO_DATA_W-1:WIDTH];
  end

  assign w_wr_en = chipselect & ~write_n;
  assign w_rise  = w_deb & ~r_deb_q;
  assign w_fall  = ~w_deb & r_deb_q;

  // Select which debounced transitions get captured.
  always_comb begin
    w_set = {WIDTH{1'b0}};
    case (EDGE_SEL)
      EDGE_RISE: w_set = w_rise;
      EDGE_FALL: w_set = w_fall;
      EDGE_ANY:  w_set = w_rise | w_fall;
      default:   w_set = {WIDTH{1'b0}};
    endcase
  end

  // W1C clear vector from an EDGECAP write.
  always_comb begin
    w_clr = {WIDTH{1'b0}};
    if (w_wr_en && (address == PIO_EDGECAP)) begin
      w_clr = writedata[WIDTH-1:0];
    end else begin
      w_clr = {WIDTH{1'b0}};
    end
  end

  // Edge history, mask, sticky capture and registered IRQ.
  // deb_q resets to the same level as deb so reset release never looks
  // like an edge. A new edge beats a simultaneous W1C on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_q    <= RESET_LEVEL;
      r_irq_mask <= {WIDTH{1'b0}};
      r_edge_cap <= {WIDTH{1'b0}};
      r_irq      <= 1'b0;
    end else begin
      r_deb_q    <= w_deb;
      r_edge_cap <= w_set | (r_edge_cap & ~w_clr);
      r_irq      <= |(r_edge_cap & r_irq_mask);
      if (w_wr_en && (address == PIO_IRQMASK)) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Zero-wait-state read mux; reads have no side effects.
  always_comb begin
    readdata = {PIO_DATA_W{1'b0}};
    case (address)
      PIO_DATA:    readdata[WIDTH-1:0] = w_deb;
      PIO_RSVD:    readdata[WIDTH-1:0] = {WIDTH{1'b0}};
      PIO_IRQMASK: readdata[WIDTH-1:0] = r_irq_mask;
      PIO_EDGECAP: readdata[WIDTH-1:0] = r_edge_cap;
      default:     readdata[WIDTH-1:0] = {WIDTH{1'b0}};
    endcase
  end

  assign irq = r_irq;

endmodule : mnist_nn_key_pio

// File: tb/tb_mnist_nn_key_pio.sv
// ---------------------------------------------------------------------------
// tb_mnist_nn_key_pio
// Directed, self-checking bench for mnist_nn_key_pio with WIDTH=4,
// DEBOUNCE_CYCLES=4, EDGE_TYPE=1 (falling), RESET_LEVEL=4'hF.
// Inputs change on the falling clock edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_mnist_nn_key_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_cmp;
  int n_err;

  mnist_nn_key_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (1),
    .RESET_LEVEL     (4'hF)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Combinational read, called on a falling edge.
  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check_value(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  // Write strobe held across exactly one rising edge; returns on the next falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0000_0000;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0000_0000;
    in_port    = 4'hF;

    // Reset state.
    wait_clks(3);
    check_value("irq_in_reset", {31'd0, irq}, 32'h0000_0000);
    reset_n = 1'b1;
    wait_clks(2);
    read_check("rst_data",    2'd0, 32'h0000_000F);
    read_check("rst_rsvd",    2'd1, 32'h0000_0000);
    read_check("rst_mask",    2'd2, 32'h0000_0000);
    read_check("rst_edgecap", 2'd3, 32'h0000_0000);
    check_value("rst_irq", {31'd0, irq}, 32'h0000_0000);

    // Bit0 falls and holds: deb[0] drops on the 6th clock, capture on the 7th.
    in_port = 4'hE;
    wait_clks(5);
    read_check("deb0_clk5", 2'd0, 32'h0000_000F);
    wait_clks(1);
    read_check("deb0_clk6", 2'd0, 32'h0000_000E);
    read_check("cap0_clk6", 2'd3, 32'h0000_0000);
    wait_clks(1);
    read_check("cap0_clk7", 2'd3, 32'h0000_0001);
    wait_clks(2);
    check_value("irq_masked0", {31'd0, irq}, 32'h0000_0000);

    // 3-clock glitch on bit1 is rejected.
    in_port = 4'hC;
    wait_clks(3);
    in_port = 4'hE;
    wait_clks(8);
    read_check("glitch_data", 2'd0, 32'h0000_000E);
    read_check("glitch_cap",  2'd3, 32'h0000_0001);

    // Writes to DATA and to unimplemented mask bits are ignored.
    bus_write(2'd0, 32'hFFFF_FFFF);
    read_check("data_wr_ignored", 2'd0, 32'h0000_000E);
    bus_write(2'd2, 32'hFFFF_FFF0);
    read_check("mask_hi_bits", 2'd2, 32'h0000_0000);

    // Unmask pending bit0: irq one clock after the mask update.
    bus_write(2'd2, 32'h0000_0001);
    check_value("irq_after_mask_0", {31'd0, irq}, 32'h0000_0000);
    read_check("mask_rd", 2'd2, 32'h0000_0001);
    wait_clks(1);
    check_value("irq_after_mask_1", {31'd0, irq}, 32'h0000_0001);
    read_check("cap_kept_by_mask", 2'd3, 32'h0000_0001);

    // W1C bit0: capture clears at once, irq drops one clock later.
    bus_write(2'd3, 32'h0000_0001);
    read_check("w1c_cap", 2'd3, 32'h0000_0000);
    check_value("w1c_irq_0", {31'd0, irq}, 32'h0000_0001);
    wait_clks(1);
    check_value("w1c_irq_1", {31'd0, irq}, 32'h0000_0000);

    // Bit2 falling edge captured on the same clock as a W1C of bit2: set wins.
    in_port = 4'hA;
    wait_clks(6);
    read_check("pre_collide_cap", 2'd3, 32'h0000_0000);
    bus_write(2'd3, 32'h0000_0004);
    read_check("collide_cap", 2'd3, 32'h0000_0004);
    read_check("collide_data", 2'd0, 32'h0000_000A);
    wait_clks(1);
    check_value("collide_irq_masked", {31'd0, irq}, 32'h0000_0000);

    // Unmasking a pending bit raises irq the next clock.
    bus_write(2'd2, 32'h0000_0004);
    wait_clks(1);
    check_value("unmask_pending_irq", {31'd0, irq}, 32'h0000_0001);

    // Reset in the middle of bit3's debounce window.
    in_port = 4'h2;
    wait_clks(3);
    reset_n = 1'b0;
    in_port = 4'hF;
    #1;
    check_value("async_rst_irq", {31'd0, irq}, 32'h0000_0000);
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(1);
    read_check("post_rst_data", 2'd0, 32'h0000_000F);
    read_check("post_rst_cap",  2'd3, 32'h0000_0000);
    read_check("post_rst_mask", 2'd2, 32'h0000_0000);
    check_value("post_rst_irq", {31'd0, irq}, 32'h0000_0000);
    wait_clks(8);
    read_check("settle_data", 2'd0, 32'h0000_000F);
    read_check("settle_cap",  2'd3, 32'h0000_0000);
    check_value("settle_irq", {31'd0, irq}, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mnist_nn_key_pio
